clause_bcp_ctrl: RTL and testbench

- Sequencer for one clause array row-set: loads clause literals into the lit cells and runs the Boolean constraint propagation (BCP) loop.
- Scans per-clause free-literal counts and satisfied flags, and grants one implication at a time (round-robin among unit clauses).
- Lets the array settle after each grant, detects conflicts and drives the conflict-clause pulse.
- Sits between the SAT engine top-level FSM and the clause array.

---
 rtl/clause_bcp_ctrl.sv | 191 +++++++++++++++++++
 tb/tb_clause_bcp_ctrl.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/clause_bcp_ctrl.sv
// BCP sequencer for one clause-array row-set: loads clause literals, scans
// unit/conflict status, grants implications round-robin and reports the outcome.
module clause_bcp_ctrl #(
  parameter int NUM_C      = 8,
  parameter int NUM_V      = 8,
  parameter int SETTLE_CYC = 2,
  parameter int CIW        = $clog2(NUM_C)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load_valid,
  output logic                 load_ready,
  input  logic [CIW-1:0]       load_cidx,
  input  logic [2*NUM_V-1:0]   load_lits,
  output logic [NUM_C-1:0]     wr_o,
  output logic [2*NUM_V-1:0]   lit_o,
  input  logic                 start_bcp,
  input  logic [2*NUM_C-1:0]   freelitcnt_i,
  input  logic [NUM_C-1:0]     clausesat_i,
  output logic [NUM_C-1:0]     imp_drv_o,
  output logic [NUM_C-1:0]     cclause_drv_o,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 conflict_o,
  output logic [CIW-1:0]       conflict_cidx_o,
  output logic [7:0]           imp_cnt_o
);

  localparam int SCW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam int PW  = CIW + 1;

  typedef enum logic [2:0] {
    IDLE, LOAD, SCAN, IMPLY, SETTLE, CONFLICT, DONE
  } state_t;

  state_t               state_reg, state_next;
  logic [CIW-1:0]       cidx_reg, cidx_next;
  logic [2*NUM_V-1:0]   lit_reg, lit_next;
  logic [NUM_C-1:0]     wr_reg, wr_next;
  logic [NUM_C-1:0]     valid_reg, valid_next;
  logic [CIW-1:0]       rr_ptr_reg, rr_ptr_next;
  logic [SCW-1:0]       settle_reg, settle_next;
  logic [NUM_C-1:0]     imp_drv_reg, imp_drv_next;
  logic [NUM_C-1:0]     cclause_reg, cclause_next;
  logic                 done_reg, done_next;
  logic                 conflict_reg, conflict_next;
  logic [CIW-1:0]       conflict_cidx_reg, conflict_cidx_next;
  logic [7:0]           imp_cnt_reg, imp_cnt_next;

  logic [NUM_C-1:0]     conflict_vec, unit_vec;
  logic [CIW-1:0]       conf_idx, grant_idx;
  logic                 grant_found;
  logic [PW-1:0]        scan_pos;

  // Per-clause status; invalid rows are masked so they never grant or conflict.
  generate
    for (genvar gi = 0; gi < NUM_C; gi++) begin : g_cls
      assign conflict_vec[gi] = valid_reg[gi] & ~clausesat_i[gi] &
                                (freelitcnt_i[2*gi+1 -: 2] == 2'b00);
      assign unit_vec[gi]     = valid_reg[gi] & ~clausesat_i[gi] &
                                (freelitcnt_i[2*gi+1 -: 2] == 2'b01);
    end
  endgenerate

  always_comb begin
    conf_idx = '0;
    for (int i = NUM_C - 1; i >= 0; i--) begin
      if (conflict_vec[i]) conf_idx = CIW'(i);
    end
  end

  // First unit clause at or after rr_ptr, wrapping modulo NUM_C.
  always_comb begin
    grant_idx   = '0;
    grant_found = 1'b0;
    scan_pos    = '0;
    for (int k = 0; k < NUM_C; k++) begin
      scan_pos = {1'b0, rr_ptr_reg} + PW'(k);
      if (scan_pos >= PW'(NUM_C)) scan_pos = scan_pos - PW'(NUM_C);
      if (!grant_found && unit_vec[scan_pos[CIW-1:0]]) begin
        grant_found = 1'b1;
        grant_idx   = scan_pos[CIW-1:0];
      end
    end
  end

  always_comb begin
    state_next         = state_reg;
    cidx_next          = cidx_reg;
    lit_next           = lit_reg;
    wr_next            = '0;
    valid_next         = valid_reg;
    rr_ptr_next        = rr_ptr_reg;
    settle_next        = settle_reg;
    imp_drv_next       = '0;
    cclause_next       = '0;
    done_next          = 1'b0;
    conflict_next      = 1'b0;
    conflict_cidx_next = conflict_cidx_reg;
    imp_cnt_next       = imp_cnt_reg;
    case (state_reg)
      IDLE: begin
        if (load_valid) begin
          state_next = LOAD;
          cidx_next  = load_cidx;
          lit_next   = load_lits;
          wr_next    = NUM_C'(1) << load_cidx;
        end else if (start_bcp) begin
          state_next         = SCAN;
          imp_cnt_next       = '0;
          conflict_cidx_next = '0;
        end
      end
      LOAD: begin
        valid_next[cidx_reg] = |lit_reg;
        state_next           = IDLE;
      end
      SCAN: begin
        if (|conflict_vec) begin
          state_next         = CONFLICT;
          conflict_cidx_next = conf_idx;
          cclause_next       = NUM_C'(1) << conf_idx;
          conflict_next      = 1'b1;
        end else if (grant_found) begin
          state_next   = IMPLY;
          imp_drv_next = NUM_C'(1) << grant_idx;
          rr_ptr_next  = (grant_idx == CIW'(NUM_C - 1)) ? '0 : grant_idx + 1'b1;
          if (imp_cnt_reg != 8'hFF) imp_cnt_next = imp_cnt_reg + 8'd1;
        end else begin
          state_next = DONE;
          done_next  = 1'b1;
        end
      end
      IMPLY: begin
        state_next  = SETTLE;
        settle_next = SCW'(SETTLE_CYC - 1);
      end
      SETTLE: begin
        if (settle_reg == '0) state_next = SCAN;
        else                  settle_next = settle_reg - 1'b1;
      end
      CONFLICT: state_next = IDLE;
      DONE:     state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg         <= IDLE;
      cidx_reg          <= '0;
      lit_reg           <= '0;
      wr_reg            <= '0;
      valid_reg         <= '0;
      rr_ptr_reg        <= '0;
      settle_reg        <= '0;
      imp_drv_reg       <= '0;
      cclause_reg       <= '0;
      done_reg          <= 1'b0;
      conflict_reg      <= 1'b0;
      conflict_cidx_reg <= '0;
      imp_cnt_reg       <= '0;
    end else begin
      state_reg         <= state_next;
      cidx_reg          <= cidx_next;
      lit_reg           <= lit_next;
      wr_reg            <= wr_next;
      valid_reg         <= valid_next;
      rr_ptr_reg        <= rr_ptr_next;
      settle_reg        <= settle_next;
      imp_drv_reg       <= imp_drv_next;
      cclause_reg       <= cclause_next;
      done_reg          <= done_next;
      conflict_reg      <= conflict_next;
      conflict_cidx_reg <= conflict_cidx_next;
      imp_cnt_reg       <= imp_cnt_next;
    end
  end

  assign load_ready      = (state_reg == IDLE);
  assign busy_o          = (state_reg != IDLE);
  assign wr_o            = wr_reg;
  assign lit_o           = lit_reg;
  assign imp_drv_o       = imp_drv_reg;
  assign cclause_drv_o   = cclause_reg;
  assign done_o          = done_reg;
  assign conflict_o      = conflict_reg;
  assign conflict_cidx_o = conflict_cidx_reg;
  assign imp_cnt_o       = imp_cnt_reg;

endmodule

// File: tb/tb_clause_bcp_ctrl.sv
// Directed self-checking bench for clause_bcp_ctrl: load, implication order,
// conflict priority, invalid clauses, load/start collision and mid-run reset.
module tb_clause_bcp_ctrl;

  localparam int NUM_C = 8;
  localparam int NUM_V = 8;
  localparam int SETTLE_CYC = 2;
  localparam int CIW = 3;

  logic                 clk = 1'b0;
  logic                 rst = 1'b0;
  logic                 load_valid = 1'b0;
  logic                 load_ready;
  logic [CIW-1:0]       load_cidx = '0;
  logic [2*NUM_V-1:0]   load_lits = '0;
  logic [NUM_C-1:0]     wr_o;
  logic [2*NUM_V-1:0]   lit_o;
  logic                 start_bcp = 1'b0;
  logic [2*NUM_C-1:0]   freelitcnt_i = '0;
  logic [NUM_C-1:0]     clausesat_i = '0;
  logic [NUM_C-1:0]     imp_drv_o;
  logic [NUM_C-1:0]     cclause_drv_o;
  logic                 busy_o;
  logic                 done_o;
  logic                 conflict_o;
  logic [CIW-1:0]       conflict_cidx_o;
  logic [7:0]           imp_cnt_o;

  int n_checks = 0;
  int n_fail = 0;

  int grant_idx_log [8];
  int grant_cyc_log [8];
  int grant_n;
  int run_end;
  logic saw_imp;

  clause_bcp_ctrl #(
    .NUM_C(NUM_C), .NUM_V(NUM_V), .SETTLE_CYC(SETTLE_CYC)
  ) dut (
    .clk(clk), .rst(rst),
    .load_valid(load_valid), .load_ready(load_ready),
    .load_cidx(load_cidx), .load_lits(load_lits),
    .wr_o(wr_o), .lit_o(lit_o),
    .start_bcp(start_bcp),
    .freelitcnt_i(freelitcnt_i), .clausesat_i(clausesat_i),
    .imp_drv_o(imp_drv_o), .cclause_drv_o(cclause_drv_o),
    .busy_o(busy_o), .done_o(done_o), .conflict_o(conflict_o),
    .conflict_cidx_o(conflict_cidx_o), .imp_cnt_o(imp_cnt_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0; load_valid = 1'b0; start_bcp = 1'b0;
    tick(); tick();
    rst = 1'b1;
  endtask

  task automatic load_clause(input logic [CIW-1:0] c, input logic [15:0] lits);
    load_valid = 1'b1; load_cidx = c; load_lits = lits;
    tick();
    load_valid = 1'b0;
    tick();
  endtask

  // Runs BCP, records every grant with its cycle and satisfies the granted clause.
  task automatic run_collect();
    grant_n = 0; run_end = 0;
    start_bcp = 1'b1;
    tick();
    start_bcp = 1'b0;
    for (int c = 1; c < 200 && run_end == 0; c++) begin
      tick();
      if (imp_drv_o != '0 && grant_n < 8) begin
        for (int i = 0; i < NUM_C; i++) if (imp_drv_o[i]) grant_idx_log[grant_n] = i;
        grant_cyc_log[grant_n] = c;
        grant_n++;
        clausesat_i = clausesat_i | imp_drv_o;
      end
      if (done_o) run_end = 1;
      else if (conflict_o) run_end = 2;
    end
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++; if (load_ready !== 1'b1) begin n_fail++; $display("FAIL reset_load_ready got=%0b exp=1", load_ready); end
    n_checks++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%0b exp=0", busy_o); end
    n_checks++; if ({wr_o, imp_drv_o, cclause_drv_o} !== 24'h0) begin n_fail++; $display("FAIL reset_drives got=%0h exp=0", {wr_o, imp_drv_o, cclause_drv_o}); end
    n_checks++; if ({done_o, conflict_o, conflict_cidx_o, imp_cnt_o, lit_o} !== '0) begin n_fail++; $display("FAIL reset_outputs got=%0h exp=0", {done_o, conflict_o, conflict_cidx_o, imp_cnt_o, lit_o}); end
    // Empty array: IDLE -> SCAN -> DONE.
    start_bcp = 1'b1;
    tick();
    start_bcp = 1'b0;
    n_checks++; if (done_o !== 1'b0 || busy_o !== 1'b1) begin n_fail++; $display("FAIL empty_scan done/busy got=%0b%0b exp=01", done_o, busy_o); end
    tick();
    n_checks++; if (done_o !== 1'b1) begin n_fail++; $display("FAIL empty_done got=%0b exp=1", done_o); end
    n_checks++; if (imp_cnt_o !== 8'd0) begin n_fail++; $display("FAIL empty_imp_cnt got=%0d exp=0", imp_cnt_o); end
    tick();
    n_checks++; if (done_o !== 1'b0 || busy_o !== 1'b0) begin n_fail++; $display("FAIL empty_after done/busy got=%0b%0b exp=00", done_o, busy_o); end
  endtask

  task automatic test_load_imply();
    load_valid = 1'b1; load_cidx = 3'd2; load_lits = 16'h0001;
    tick();
    load_valid = 1'b0;
    n_checks++; if (wr_o !== 8'h04) begin n_fail++; $display("FAIL load_wr got=%0h exp=04", wr_o); end
    n_checks++; if (lit_o !== 16'h0001) begin n_fail++; $display("FAIL load_lit got=%0h exp=0001", lit_o); end
    n_checks++; if (load_ready !== 1'b0) begin n_fail++; $display("FAIL load_ready_in_load got=%0b exp=0", load_ready); end
    tick();
    n_checks++; if (wr_o !== 8'h00 || lit_o !== 16'h0001) begin n_fail++; $display("FAIL load_after wr=%0h lit=%0h exp wr=00 lit=0001", wr_o, lit_o); end
    freelitcnt_i = 16'h0010; clausesat_i = 8'h00;
    start_bcp = 1'b1;
    tick();
    start_bcp = 1'b0;
    n_checks++; if (imp_drv_o !== 8'h00) begin n_fail++; $display("FAIL imply_scan_drv got=%0h exp=00", imp_drv_o); end
    tick();
    n_checks++; if (imp_drv_o !== 8'h04) begin n_fail++; $display("FAIL imply_drv got=%0h exp=04", imp_drv_o); end
    n_checks++; if (cclause_drv_o !== 8'h00) begin n_fail++; $display("FAIL imply_cclause got=%0h exp=00", cclause_drv_o); end
    tick();
    n_checks++; if (imp_drv_o !== 8'h00) begin n_fail++; $display("FAIL imply_drv_pulse got=%0h exp=00", imp_drv_o); end
    clausesat_i = 8'h04;
    tick(); tick(); tick();
    n_checks++; if (done_o !== 1'b1) begin n_fail++; $display("FAIL imply_done got=%0b exp=1", done_o); end
    n_checks++; if (imp_cnt_o !== 8'd1) begin n_fail++; $display("FAIL imply_cnt got=%0d exp=1", imp_cnt_o); end
    tick();
  endtask

  task automatic test_round_robin();
    do_reset();
    load_clause(3'd1, 16'h0002);
    load_clause(3'd3, 16'h0002);
    load_clause(3'd6, 16'h0002);
    freelitcnt_i = 16'h1044; clausesat_i = 8'h00;
    run_collect();
    n_checks++; if (run_end !== 1 || grant_n !== 3) begin n_fail++; $display("FAIL rr1_end got end=%0d grants=%0d exp end=1 grants=3", run_end, grant_n); end
    n_checks++; if (grant_idx_log[0] !== 1 || grant_idx_log[1] !== 3 || grant_idx_log[2] !== 6) begin n_fail++; $display("FAIL rr1_order got=%0d,%0d,%0d exp=1,3,6", grant_idx_log[0], grant_idx_log[1], grant_idx_log[2]); end
    n_checks++; if (grant_cyc_log[1] - grant_cyc_log[0] !== 4 || grant_cyc_log[2] - grant_cyc_log[1] !== 4) begin n_fail++; $display("FAIL rr1_spacing got=%0d,%0d exp=4,4", grant_cyc_log[1] - grant_cyc_log[0], grant_cyc_log[2] - grant_cyc_log[1]); end
    n_checks++; if (imp_cnt_o !== 8'd3) begin n_fail++; $display("FAIL rr1_cnt got=%0d exp=3", imp_cnt_o); end
    tick();
    load_clause(3'd0, 16'h0001);
    freelitcnt_i = 16'h1001; clausesat_i = 8'h0A;
    run_collect();
    n_checks++; if (run_end !== 1 || grant_n !== 2) begin n_fail++; $display("FAIL rr2_end got end=%0d grants=%0d exp end=1 grants=2", run_end, grant_n); end
    n_checks++; if (grant_idx_log[0] !== 0 || grant_idx_log[1] !== 6) begin n_fail++; $display("FAIL rr2_order got=%0d,%0d exp=0,6", grant_idx_log[0], grant_idx_log[1]); end
    n_checks++; if (imp_cnt_o !== 8'd2) begin n_fail++; $display("FAIL rr2_cnt got=%0d exp=2", imp_cnt_o); end
    tick();
  endtask

  task automatic test_conflict();
    do_reset();
    load_clause(3'd4, 16'h0003);
    load_clause(3'd5, 16'h0003);
    freelitcnt_i = 16'h0400; clausesat_i = 8'h00;
    saw_imp = 1'b0;
    start_bcp = 1'b1;
    tick();
    start_bcp = 1'b0;
    saw_imp = saw_imp | (|imp_drv_o);
    tick();
    saw_imp = saw_imp | (|imp_drv_o);
    n_checks++; if (cclause_drv_o !== 8'h10) begin n_fail++; $display("FAIL conf_drv got=%0h exp=10", cclause_drv_o); end
    n_checks++; if (conflict_o !== 1'b1 || done_o !== 1'b0) begin n_fail++; $display("FAIL conf_pulse conflict/done got=%0b%0b exp=10", conflict_o, done_o); end
    n_checks++; if (conflict_cidx_o !== 3'd4) begin n_fail++; $display("FAIL conf_cidx got=%0d exp=4", conflict_cidx_o); end
    n_checks++; if (saw_imp !== 1'b0) begin n_fail++; $display("FAIL conf_no_imply got=%0b exp=0", saw_imp); end
    tick();
    n_checks++; if (conflict_o !== 1'b0 || cclause_drv_o !== 8'h00 || conflict_cidx_o !== 3'd4) begin n_fail++; $display("FAIL conf_after pulse=%0b drv=%0h cidx=%0d exp 0,00,4", conflict_o, cclause_drv_o, conflict_cidx_o); end
    // A clean run clears the held conflict index at start.
    clausesat_i = 8'h30;
    start_bcp = 1'b1;
    tick();
    start_bcp = 1'b0;
    n_checks++; if (conflict_cidx_o !== 3'd0) begin n_fail++; $display("FAIL conf_cidx_clear got=%0d exp=0", conflict_cidx_o); end
    tick();
    n_checks++; if (done_o !== 1'b1) begin n_fail++; $display("FAIL conf_clean_done got=%0b exp=1", done_o); end
    tick();
  endtask

  task automatic test_back_to_back();
    do_reset();
    load_clause(3'd7, 16'h0000);
    freelitcnt_i = 16'h0000; clausesat_i = 8'h00;
    start_bcp = 1'b1;
    tick();
    start_bcp = 1'b0;
    tick();
    n_checks++; if (done_o !== 1'b1 || conflict_o !== 1'b0) begin n_fail++; $display("FAIL zero_lits done/conflict got=%0b%0b exp=10", done_o, conflict_o); end
    tick();
    // Load and start together: the load wins and the start is dropped.
    load_valid = 1'b1; start_bcp = 1'b1; load_cidx = 3'd7; load_lits = 16'h8000;
    tick();
    load_valid = 1'b0; start_bcp = 1'b0;
    n_checks++; if (wr_o !== 8'h80 || lit_o !== 16'h8000) begin n_fail++; $display("FAIL collide_load wr=%0h lit=%0h exp wr=80 lit=8000", wr_o, lit_o); end
    tick();
    n_checks++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL collide_idle got=%0b exp=0", busy_o); end
    tick();
    n_checks++; if (busy_o !== 1'b0 || done_o !== 1'b0 || conflict_o !== 1'b0) begin n_fail++; $display("FAIL collide_no_run busy/done/conflict got=%0b%0b%0b exp=000", busy_o, done_o, conflict_o); end
    // Clause 7 now valid with no free literal: a real start must conflict on it.
    start_bcp = 1'b1;
    tick();
    start_bcp = 1'b0;
    tick();
    n_checks++; if (conflict_o !== 1'b1 || conflict_cidx_o !== 3'd7 || cclause_drv_o !== 8'h80) begin n_fail++; $display("FAIL reload_conflict pulse=%0b cidx=%0d drv=%0h exp 1,7,80", conflict_o, conflict_cidx_o, cclause_drv_o); end
    tick();
  endtask

  task automatic test_mid_reset();
    do_reset();
    load_clause(3'd2, 16'h0001);
    load_clause(3'd5, 16'h0001);
    freelitcnt_i = 16'h0410; clausesat_i = 8'h00;
    start_bcp = 1'b1;
    tick();
    start_bcp = 1'b0;
    tick();
    n_checks++; if (imp_drv_o !== 8'h04) begin n_fail++; $display("FAIL midrst_first_grant got=%0h exp=04", imp_drv_o); end
    tick();
    rst = 1'b0;
    tick();
    n_checks++; if (busy_o !== 1'b0 || load_ready !== 1'b1) begin n_fail++; $display("FAIL midrst_idle busy/ready got=%0b%0b exp=01", busy_o, load_ready); end
    n_checks++; if ({imp_drv_o, cclause_drv_o, done_o, conflict_o} !== 18'h0 || imp_cnt_o !== 8'd0) begin n_fail++; $display("FAIL midrst_outputs got=%0h cnt=%0d exp=0", {imp_drv_o, cclause_drv_o, done_o, conflict_o}, imp_cnt_o); end
    rst = 1'b1;
    tick();
    n_checks++; if (done_o !== 1'b0 || conflict_o !== 1'b0 || busy_o !== 1'b0) begin n_fail++; $display("FAIL midrst_no_pulse done/conflict/busy got=%0b%0b%0b exp=000", done_o, conflict_o, busy_o); end
    load_clause(3'd2, 16'h0001);
    load_clause(3'd5, 16'h0001);
    start_bcp = 1'b1;
    tick();
    start_bcp = 1'b0;
    tick();
    n_checks++; if (imp_drv_o !== 8'h04) begin n_fail++; $display("FAIL midrst_rr_cleared got=%0h exp=04", imp_drv_o); end
    tick();
  endtask

  initial begin
    test_reset();
    test_load_imply();
    test_round_robin();
    test_conflict();
    test_back_to_back();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
